// File: rtl/tr_arb_pkg.sv
// Shared types and widths for the transmit-port arbiter and its round-robin picker.
package tr_arb_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OWNER_W = 3;
  localparam int unsigned TMO_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    FIRE,
    GAP
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } tr_word_t;

endpackage

// File: rtl/tr_port_arbiter_if.sv
// Requester-side and transmit-side signals of the shared TR_IN word port.
interface tr_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import tr_arb_pkg::*;

  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ-1:0]        LOCK;
  logic [ADDR_W*NUM_REQ-1:0] ADDR;
  logic [DATA_W*NUM_REQ-1:0] DATA;
  logic [NUM_REQ-1:0]        ACK;
  logic                      TR_IN;
  logic [ADDR_W-1:0]         ADDR_IN;
  logic [DATA_W-1:0]         DATA_IN;
  logic                      TR_IN_BUSY;
  logic [OWNER_W-1:0]        OWNER;
  logic                      ACTIVE;
  logic                      ERR_TIMEOUT;
  logic                      ERR_CLR;

  modport master (
    output REQ, LOCK, ADDR, DATA, TR_IN_BUSY, ERR_CLR,
    input  ACK, TR_IN, ADDR_IN, DATA_IN, OWNER, ACTIVE, ERR_TIMEOUT
  );

  modport slave (
    input  REQ, LOCK, ADDR, DATA, TR_IN_BUSY, ERR_CLR,
    output ACK, TR_IN, ADDR_IN, DATA_IN, OWNER, ACTIVE, ERR_TIMEOUT
  );

endinterface

// File: rtl/tr_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid_c,
  output logic [IDX_W-1:0]   idx_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand;

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!valid_c && req[cand[IDX_W-1:0]]) begin
        valid_c = 1'b1;
        idx_c   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tr_port_arbiter.sv
// Shares the TR_IN/ADDR_IN/DATA_IN word port between NUM_REQ sources with
// round-robin arbitration, optional frame lock, BUSY pacing and a drop watchdog.
module tr_port_arbiter
  import tr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned MAX_BURST      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              CLK,
  input logic              RESET,
  tr_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               lock_vld_q, lock_vld_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               dropped_q, dropped_d;
  tr_word_t           word_q, word_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tr_in_q, tr_in_d;
  logic               active_q, active_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] req_mask_c;
  logic               pick_valid_c;
  logic [IDX_W-1:0]   pick_idx_c;

  // A held lock hides every request except the lock owner's.
  assign req_mask_c = lock_vld_q ? (bus.REQ & (ONE_HOT0 << owner_q)) : bus.REQ;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_mask_c),
    .ptr     (rr_ptr_q),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      lock_vld_q <= 1'b0;
      tmo_q      <= '0;
      gap_q      <= '0;
      dropped_q  <= 1'b0;
      word_q     <= '0;
      ack_q      <= '0;
      tr_in_q    <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      lock_vld_q <= lock_vld_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      dropped_q  <= dropped_d;
      word_q     <= word_d;
      ack_q      <= ack_d;
      tr_in_q    <= tr_in_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    lock_vld_d = lock_vld_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    dropped_d  = dropped_q;
    word_d     = word_q;
    err_d      = err_q & ~bus.ERR_CLR;

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          owner_d     = pick_idx_c;
          word_d.addr = bus.ADDR[ADDR_W*pick_idx_c +: ADDR_W];
          word_d.data = bus.DATA[DATA_W*pick_idx_c +: DATA_W];
          state_d     = GRANT;
        end
      end
      GRANT: begin
        rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        burst_d   = burst_q + BURST_W'(1);
        tmo_d     = '0;
        dropped_d = 1'b0;
        state_d   = bus.TR_IN_BUSY ? WAIT : FIRE;
      end
      WAIT: begin
        if (!bus.TR_IN_BUSY) begin
          state_d = FIRE;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
          // Watchdog: drop the word, flag it and release any frame lock.
          if ((TIMEOUT_CYCLES != 0) && (tmo_d >= TMO_W'(TIMEOUT_CYCLES))) begin
            err_d      = 1'b1;
            lock_vld_d = 1'b0;
            dropped_d  = 1'b1;
            gap_d      = '0;
            state_d    = GAP;
          end
        end
      end
      FIRE: begin
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          if (bus.LOCK[owner_q] && !dropped_q && (burst_q < BURST_W'(MAX_BURST))) begin
            lock_vld_d = 1'b1;
          end else begin
            lock_vld_d = 1'b0;
            burst_d    = '0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ack_d    = (state_d == GRANT) ? (ONE_HOT0 << owner_d) : '0;
    tr_in_d  = (state_d == FIRE);
    active_d = (state_d != IDLE);
  end

  assign bus.ACK         = ack_q;
  assign bus.TR_IN       = tr_in_q;
  assign bus.ADDR_IN     = word_q.addr;
  assign bus.DATA_IN     = word_q.data;
  assign bus.OWNER       = OWNER_W'(owner_q);
  assign bus.ACTIVE      = active_q;
  assign bus.ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_tr_port_arbiter.sv
// Directed bench for tr_port_arbiter: requester models feed a scoreboard of
// expected words that is checked on every TR_IN strobe.
module tb_tr_port_arbiter;
  import tr_arb_pkg::*;

  localparam int unsigned NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tr_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  tr_port_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (2),
    .MAX_BURST      (32),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned own;
    logic [15:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rem[NUM_REQ];
  int          seq[NUM_REQ];
  bit          lock_en[NUM_REQ];
  logic [15:0] cur_a[NUM_REQ];
  logic [31:0] cur_d[NUM_REQ];
  int          tr_count = 0;
  int          tr_cyc = 0;
  int          last_tr = -1;
  bit          chk_gap = 1'b0;

  function automatic logic [15:0] word_a(int i, int k);
    return 16'(i * 256 + k);
  endfunction

  function automatic logic [31:0] word_d(int i, int k);
    return 32'(32'hC0DE_0000 + i * 4096 + k * 3);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(int i, int n, bit lk);
    rem[i]     = n;
    seq[i]     = 0;
    lock_en[i] = lk;
    cur_a[i]   = word_a(i, 0);
    cur_d[i]   = word_d(i, 0);
  endtask

  task automatic expect_word(int i, int k);
    exp_t e;
    e.own = i;
    e.a   = word_a(i, k);
    e.d   = word_d(i, k);
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.REQ[i]            = (rem[i] > 0);
      bus.LOCK[i]           = lock_en[i] && (rem[i] > 0);
      bus.ADDR[16*i +: 16]  = cur_a[i];
      bus.DATA[32*i +: 32]  = cur_d[i];
    end
  endtask

  // One clock: sample outputs on the falling edge, score TR_IN, advance requesters on ACK.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.TR_IN === 1'b1) begin
      tr_count++;
      if (chk_gap && last_tr >= 0) check("tr_spacing", 64'(cyc - last_tr), 64'(5));
      last_tr = cyc;
      tr_cyc  = cyc;
      tests++;
      assert (sb.size() > 0)
      else begin
        fails++;
        $error("FAIL tr_unexpected: observed TR_IN addr %0h, expected no transfer", bus.ADDR_IN);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tr_owner", 64'(bus.OWNER), 64'(e.own));
        check("tr_addr", 64'(bus.ADDR_IN), 64'(e.a));
        check("tr_data", 64'(bus.DATA_IN), 64'(e.d));
      end
    end
    if (bus.ACK !== '0) begin
      check("ack_onehot", 64'($onehot(bus.ACK)), 64'(1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.ACK[i] === 1'b1 && rem[i] > 0) begin
          rem[i]--;
          seq[i]++;
          cur_a[i] = word_a(i, seq[i]);
          cur_d[i] = word_d(i, seq[i]);
        end
      end
    end
    drive();
  endtask

  task automatic run_drain(string tag, int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'(0));
    repeat (4) step();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ack"},    64'(bus.ACK), 64'(0));
    check({tag, "_tr_in"},  64'(bus.TR_IN), 64'(0));
    check({tag, "_addr"},   64'(bus.ADDR_IN), 64'(0));
    check({tag, "_data"},   64'(bus.DATA_IN), 64'(0));
    check({tag, "_owner"},  64'(bus.OWNER), 64'(0));
    check({tag, "_active"}, 64'(bus.ACTIVE), 64'(0));
    check({tag, "_err"},    64'(bus.ERR_TIMEOUT), 64'(0));
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) load(i, 0, 1'b0);
    sb.delete();
    bus.TR_IN_BUSY = 1'b0;
    bus.ERR_CLR    = 1'b0;
    drive();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    int fall_cyc;

    do_reset();
    check_all_zero("reset");

    // Single requester: ACK one cycle after the decision, TR_IN one after that.
    load(0, 1, 1'b0);
    cur_a[0] = 16'h0012;
    cur_d[0] = 32'hDEADBEEF;
    begin
      exp_t e;
      e.own = 0; e.a = 16'h0012; e.d = 32'hDEADBEEF;
      sb.push_back(e);
    end
    drive();
    step();
    check("single_ack", 64'(bus.ACK), 64'(4'b0001));
    check("single_tr_early", 64'(bus.TR_IN), 64'(0));
    check("single_active", 64'(bus.ACTIVE), 64'(1));
    step();
    check("single_tr", 64'(bus.TR_IN), 64'(1));
    check("single_addr_in", 64'(bus.ADDR_IN), 64'(16'h0012));
    check("single_data_in", 64'(bus.DATA_IN), 64'(32'hDEADBEEF));
    step();
    step();
    check("single_gap_active", 64'(bus.ACTIVE), 64'(1));
    step();
    check("single_idle", 64'(bus.ACTIVE), 64'(0));

    // All four requesting: order 0,1,2,3,0 with 5-cycle spacing.
    do_reset();
    load(0, 2, 1'b0); load(1, 1, 1'b0); load(2, 1, 1'b0); load(3, 1, 1'b0);
    expect_word(0, 0); expect_word(1, 0); expect_word(2, 0); expect_word(3, 0); expect_word(0, 1);
    chk_gap = 1'b1;
    last_tr = -1;
    drive();
    run_drain("rr", 60);
    chk_gap = 1'b0;

    // Locked 21-word frame from 1 while 2 waits.
    load(1, 21, 1'b1); load(2, 1, 1'b0);
    for (int k = 0; k < 21; k++) expect_word(1, k);
    expect_word(2, 0);
    drive();
    run_drain("lock21", 300);

    // Locked 40-word frame: 32 to 1, one to 2, then 1 resumes.
    load(1, 40, 1'b1); load(2, 1, 1'b0);
    for (int k = 0; k < 32; k++) expect_word(1, k);
    expect_word(2, 0);
    for (int k = 32; k < 40; k++) expect_word(1, k);
    drive();
    run_drain("lock40", 500);

    // BUSY high for 10 cycles, then TR_IN on the cycle after it falls.
    bus.TR_IN_BUSY = 1'b1;
    load(3, 1, 1'b0);
    expect_word(3, 0);
    drive();
    n0 = tr_count;
    repeat (10) step();
    check("busy_hold_tr", 64'(tr_count - n0), 64'(0));
    check("busy_hold_active", 64'(bus.ACTIVE), 64'(1));
    bus.TR_IN_BUSY = 1'b0;
    fall_cyc = cyc;
    repeat (8) step();
    check("busy_tr_once", 64'(tr_count - n0), 64'(1));
    check("busy_tr_cycle", 64'(tr_cyc), 64'(fall_cyc + 1));
    check("busy_sb_empty", 64'(sb.size()), 64'(0));

    // Watchdog: word from 0 dropped, 1 served afterwards, flag sticky until cleared.
    bus.TR_IN_BUSY = 1'b1;
    load(0, 1, 1'b0); load(1, 1, 1'b0);
    expect_word(1, 0);
    drive();
    n0 = tr_count;
    repeat (1020) step();
    check("tmo_err_early", 64'(bus.ERR_TIMEOUT), 64'(0));
    repeat (10) step();
    check("tmo_err_set", 64'(bus.ERR_TIMEOUT), 64'(1));
    check("tmo_no_tr", 64'(tr_count - n0), 64'(0));
    bus.TR_IN_BUSY = 1'b0;
    run_drain("tmo", 20);
    check("tmo_err_sticky", 64'(bus.ERR_TIMEOUT), 64'(1));
    bus.ERR_CLR = 1'b1;
    step();
    bus.ERR_CLR = 1'b0;
    check("tmo_err_clr", 64'(bus.ERR_TIMEOUT), 64'(0));

    // Reset while waiting on BUSY: outputs clear, word lost, pointer back to 0.
    bus.TR_IN_BUSY = 1'b1;
    load(2, 1, 1'b0);
    drive();
    repeat (4) step();
    check("rstw_active", 64'(bus.ACTIVE), 64'(1));
    check("rstw_owner", 64'(bus.OWNER), 64'(2));
    rst = 1'b1;
    step();
    check_all_zero("rstw");
    rst = 1'b0;
    bus.TR_IN_BUSY = 1'b0;
    load(1, 1, 1'b0); load(0, 1, 1'b0); load(3, 1, 1'b0);
    expect_word(0, 0); expect_word(1, 0); expect_word(3, 0);
    drive();
    run_drain("post_rst", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish within time limit");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/tr_port_arbiter.md
Name: tr_port_arbiter

Overview:
- Shares the single transmit-side TR_IN / ADDR_IN / DATA_IN word interface between NUM_REQ word sources, e.g. the receiver-FIFO drain and the GPS status frame sender.
- Round-robin arbitration, with an optional per-requester LOCK that holds ownership across a multi-word frame.
- Paces transfers against TR_IN_BUSY.
- Has a watchdog that discards a word when the downstream stays busy too long.
- Sits in the TR_CLK domain between the collectors and the transmit block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles after each TR_IN pulse before the next decision (>=1, covers BUSY rise latency).
- MAX_BURST, 32, maximum consecutive words one locked owner may send before a forced re-arbitration.
- TIMEOUT_CYCLES, 1024, cycles TR_IN_BUSY may stay high in WAIT before the word is dropped; 0 disables the watchdog.

Ports:
- CLK  in  1  transmit clock (TR_CLK domain)
- RESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester word valid; held until the matching ACK
- LOCK  in  NUM_REQ  per-requester "more words follow, keep grant"
- ADDR  in  16*NUM_REQ  packed addresses, slice i = ADDR[16*i+15:16*i]
- DATA  in  32*NUM_REQ  packed data, slice i = DATA[32*i+31:32*i]
- ACK  out  NUM_REQ  one-cycle word-taken pulse to the winner
- TR_IN  out  1  one-cycle transfer strobe
- ADDR_IN  out  16  registered address
- DATA_IN  out  32  registered data
- TR_IN_BUSY  in  1  downstream busy
- OWNER  out  3  index of the current or last granted requester
- ACTIVE  out  1  high in any state other than IDLE
- ERR_TIMEOUT  out  1  sticky flag: a word was dropped by the watchdog
- ERR_CLR  in  1  clears ERR_TIMEOUT

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - State = IDLE; ACK = 0, TR_IN = 0, ADDR_IN = 0, DATA_IN = 0, OWNER = 0, ACTIVE = 0, ERR_TIMEOUT = 0.
  - RR pointer = 0, burst count = 0, lock owner cleared.
  - Reset mid-transfer aborts with no TR_IN and no ACK.
- State machine: IDLE -> GRANT -> WAIT -> FIRE -> GAP -> IDLE/GRANT.
- IDLE:
  - If a lock owner is held: only its REQ is considered. If REQ is low, stay in IDLE; the lock persists until the owner drops LOCK.
  - Otherwise the winner is the first set REQ bit searching from the RR pointer upward, wrapping at NUM_REQ.
  - On a winner: register OWNER, latch its ADDR/DATA slice into ADDR_IN/DATA_IN, go to GRANT.
- GRANT (1 cycle):
  - ACK[OWNER] = 1.
  - RR pointer <= (OWNER+1) mod NUM_REQ.
  - burst count +1.
  - Requester may change ADDR/DATA/REQ from the next cycle.
- WAIT:
  - If TR_IN_BUSY = 0 -> FIRE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES (if nonzero): set ERR_TIMEOUT, go to GAP with no TR_IN, and clear the lock owner.
- FIRE: TR_IN = 1 for exactly one cycle; ADDR_IN/DATA_IN stable from GRANT through FIRE.
- GAP:
  - Count GAP_CYCLES, then decide.
  - If LOCK[OWNER] = 1 and burst count < MAX_BURST: hold the lock owner, go to IDLE.
  - Otherwise clear the lock owner and burst count, go to IDLE.
- Latency: REQ sampled in IDLE at cycle t -> ACK at t+1 -> TR_IN at t+2 at the earliest (BUSY low). Minimum word period = 3 + GAP_CYCLES cycles.
- Lock arbitration:
  - LOCK is sampled only in GAP.
  - While locked, other requests wait.
  - On reaching MAX_BURST, the RR pointer (already OWNER+1) lets others in before the owner is re-granted.
- Simultaneous events:
  - ERR_CLR and a new timeout in the same cycle -> ERR_TIMEOUT = 1 (set wins).
  - REQ dropping before ACK is a protocol violation; the word is still sent from latched values.
- Width/wrap rules:
  - Timeout counter is 16 bits, saturating.
  - Burst counter is clog2(MAX_BURST+1) bits.
  - OWNER is zero-extended to 3 bits.

Decomposition:
- Shared package tr_arb_pkg: state enum {IDLE, GRANT, WAIT, FIRE, GAP}, the ADDR/DATA width constants 16/32, and an OWNER width constant of 3.
- One sub-module: rr_pick (combinational-plus-pointer round-robin picker; inputs REQ, pointer; outputs valid and index), reusable by other collectors.

Test Plan:
- Single requester: REQ[0]=1, ADDR=0x0012, DATA=0xDEADBEEF, BUSY=0 -> ACK[0] 1 cycle later, TR_IN 1 cycle after that with ADDR_IN=0x0012, DATA_IN=0xDEADBEEF; next decision after 2 GAP cycles.
- All four REQ held high, no LOCK -> grant order 0,1,2,3,0, each TR_IN spaced 5 cycles apart.
- REQ[1]+LOCK[1] for a 21-word frame while REQ[2] is high -> 21 consecutive grants to 1, then 2. With a 40-word frame and MAX_BURST=32 -> 32 words to 1, one to 2, then 1 resumes.
- TR_IN_BUSY held high 1024 cycles with TIMEOUT_CYCLES=1024 -> no TR_IN, ERR_TIMEOUT=1, next requester served. ERR_CLR -> flag 0.
- BUSY high 10 cycles then low -> TR_IN exactly once, on the cycle after BUSY falls (+1 register), data unchanged.
- RESET asserted during WAIT -> all outputs 0 next cycle; pending word not sent; arbitration restarts at requester 0.
